// File: rtl/pixel_readout_pkg.sv
// Shared configuration for the pixel sensor readout path.
// Defaults and the readout FSM state encoding.
package PixelSensorConfig;

   localparam int SENSOR_PIXEL_BITS     = 8;
   localparam int SENSOR_NUM_PIXELS     = 4;
   localparam int READOUT_SETTLE_CYCLES = 1;
   localparam int READOUT_FIFO_DEPTH    = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      WAIT_SPACE,
      DONE
   } ReadoutState;

endpackage

// File: rtl/pixel_readout_fifo.sv
// First-word-fall-through capture FIFO for {index, value} entries.
// Power-of-two depth, so pointers wrap naturally.
module pixel_readout_fifo
   import PixelSensorConfig::*;
#(
   parameter int W     = 10,
   parameter int DEPTH = READOUT_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push)
            r_wr <= r_wr + 1'b1;
         if (w_do_pop)
            r_rd <= r_rd + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_readout.sv
// Sequential READ/DATA bus readout: selects each pixel, lets the bus
// settle, captures {index, value} into a FWFT FIFO drained by a stream.
module pixel_readout
   import PixelSensorConfig::*;
#(
   parameter int PIXEL_BITS    = SENSOR_PIXEL_BITS,
   parameter int NUM_PIXELS    = SENSOR_NUM_PIXELS,
   parameter int SETTLE_CYCLES = READOUT_SETTLE_CYCLES,
   parameter int FIFO_DEPTH    = READOUT_FIFO_DEPTH,
   parameter int IDX_W         = $clog2(NUM_PIXELS)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [NUM_PIXELS-1:0] pixel_read,
   input  logic [PIXEL_BITS-1:0] pixel_data,
   output logic                  busy,
   output logic                  done,
   output logic [PIXEL_BITS-1:0] out_data,
   output logic [IDX_W-1:0]      out_index,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam int FW    = IDX_W + PIXEL_BITS;
   localparam int AW    = $clog2(FIFO_DEPTH);

   ReadoutState      r_state;
   ReadoutState      w_next;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             w_adv;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [AW:0]      w_count;
   logic [FW-1:0]    w_dout;
   logic             w_last;
   logic             w_settled;

   assign w_last    = (r_idx == IDX_W'(NUM_PIXELS - 1));
   assign w_settled = (r_cnt == CNT_W'(SETTLE_CYCLES));

   always_comb begin
      w_next   = r_state;
      w_idx_nx = r_idx;
      w_cnt_nx = r_cnt;
      w_adv    = 1'b0;
      w_push   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_next   = SETTLE;
               w_idx_nx = '0;
               w_cnt_nx = '0;
            end
         end
         SETTLE: begin
            if (!w_settled)
               w_cnt_nx = r_cnt + 1'b1;
            else if (w_full)
               w_next = WAIT_SPACE;
            else
               w_adv = 1'b1;
         end
         WAIT_SPACE: begin
            if (!w_full)
               w_adv = 1'b1;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      // Select moves to the next pixel on the same edge as the capture
      if (w_adv) begin
         w_push = 1'b1;
         if (w_last) begin
            w_next = DONE;
         end else begin
            w_idx_nx = r_idx + 1'b1;
            w_cnt_nx = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_idx   <= w_idx_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   assign pixel_read = (r_state == SETTLE || r_state == WAIT_SPACE)
                     ? (NUM_PIXELS'(1) << r_idx) : '0;
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign out_valid  = (w_count != '0);

   assign {out_index, out_data} = w_empty ? '0 : w_dout;

   pixel_readout_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (out_valid && out_ready),
      .din   ({r_idx, pixel_data}),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: default, shallow-FIFO and
// zero-settle instances driven from one linear stimulus sequence.
module tb_pixel_readout;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic [7:0] pv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   logic       a_start, a_ready, a_busy, a_done, a_ov;
   logic [3:0] a_rd;
   logic [7:0] a_pd, a_od;
   logic [1:0] a_oi;
   logic       b_start, b_ready, b_busy, b_done, b_ov;
   logic [3:0] b_rd;
   logic [7:0] b_pd, b_od;
   logic [1:0] b_oi;
   logic       c_start, c_ready, c_busy, c_done, c_ov;
   logic [3:0] c_rd;
   logic [7:0] c_pd, c_od;
   logic [1:0] c_oi;

   // Wired-OR bus: overlapping enables would corrupt the captured value
   function automatic logic [7:0] bus(input logic [3:0] rd);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < 4; i++)
         if (rd[i]) v = v | pv[i];
      return v;
   endfunction

   assign a_pd = bus(a_rd);
   assign b_pd = bus(b_rd);
   assign c_pd = bus(c_rd);

   pixel_readout dut_a (
      .clk(clk), .reset(rst_n), .start(a_start), .pixel_read(a_rd),
      .pixel_data(a_pd), .busy(a_busy), .done(a_done), .out_data(a_od),
      .out_index(a_oi), .out_valid(a_ov), .out_ready(a_ready)
   );

   pixel_readout #(.FIFO_DEPTH(2)) dut_b (
      .clk(clk), .reset(rst_n), .start(b_start), .pixel_read(b_rd),
      .pixel_data(b_pd), .busy(b_busy), .done(b_done), .out_data(b_od),
      .out_index(b_oi), .out_valid(b_ov), .out_ready(b_ready)
   );

   pixel_readout #(.SETTLE_CYCLES(0)) dut_c (
      .clk(clk), .reset(rst_n), .start(c_start), .pixel_read(c_rd),
      .pixel_data(c_pd), .busy(c_busy), .done(c_done), .out_data(c_od),
      .out_index(c_oi), .out_valid(c_ov), .out_ready(c_ready)
   );

   logic [9:0] qa [$];
   logic [9:0] qb [$];
   logic [9:0] qc [$];
   int a_dn = 0, b_dn = 0, c_dn = 0, oh_err = 0;

   always @(posedge clk) begin
      if (a_ov && a_ready) qa.push_back({a_oi, a_od});
      if (b_ov && b_ready) qb.push_back({b_oi, b_od});
      if (c_ov && c_ready) qc.push_back({c_oi, c_od});
      if (a_done) a_dn++;
      if (b_done) b_dn++;
      if (c_done) c_dn++;
      if ($countones(a_rd) > 1 || $countones(b_rd) > 1 || $countones(c_rd) > 1)
         oh_err++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_frame(input string tag, input logic [9:0] q [$], input int n);
      chk({tag, "_len"}, q.size(), n);
      for (int i = 0; i < n; i++)
         chk(tag, (i < q.size()) ? 32'(q[i]) : 32'hdead,
             {22'd0, 2'(i % 4), pv[i % 4]});
   endtask

   initial begin
      int k;
      rst_n   = 1'b0;
      a_start = 0; a_ready = 0;
      b_start = 0; b_ready = 0;
      c_start = 0; c_ready = 0;
      tick(2);
      chk("rst_read", a_rd, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_valid", a_ov, 0);
      chk("rst_data", a_od, 0);
      chk("rst_index", a_oi, 0);
      rst_n = 1'b1;
      tick();

      // basic frame
      a_ready = 1; a_start = 1;
      tick();
      a_start = 0;
      chk("basic_busy", a_busy, 1);
      chk("basic_sel0", a_rd, 4'b0001);
      tick(7);
      chk("basic_done_early", a_done, 0);
      chk("basic_sel3", a_rd, 4'b1000);
      tick();
      chk("basic_done", a_done, 1);
      chk("basic_busy_done", a_busy, 1);
      tick();
      chk("basic_done_pulse", a_done, 0);
      chk("basic_busy_end", a_busy, 0);
      chk("basic_read_end", a_rd, 0);
      tick(2);
      chk_frame("basic", qa, 4);
      chk("basic_dn", a_dn, 1);

      // ignored restart
      qa.delete(); a_dn = 0;
      a_start = 1; tick(); a_start = 0;
      tick(2);
      a_start = 1; tick(); a_start = 0;
      tick();
      a_start = 1; tick(); a_start = 0;
      tick(10);
      chk_frame("restart", qa, 4);
      chk("restart_dn", a_dn, 1);

      // back-to-back frames, consumer stalled
      qa.delete(); a_dn = 0;
      a_ready = 0;
      a_start = 1; tick(); a_start = 0;
      k = 0;
      while (!a_done && k < 40) begin tick(); k++; end
      chk("b2b_done1", a_done, 1);
      tick();
      a_start = 1; tick(); a_start = 0;
      k = 0;
      while (!a_done && k < 40) begin tick(); k++; end
      chk("b2b_done2", a_done, 1);
      tick();
      chk("b2b_valid", a_ov, 1);
      a_ready = 1;
      tick(10);
      chk_frame("b2b", qa, 8);
      chk("b2b_dn", a_dn, 2);

      // reset mid-frame
      qa.delete();
      a_ready = 0;
      a_start = 1; tick(); a_start = 0;
      tick(4);
      chk("mid_sel2", a_rd, 4'b0100);
      chk("mid_valid", a_ov, 1);
      chk("mid_data", a_od, 8'h11);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_read", a_rd, 0);
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_valid", a_ov, 0);
      chk("mid_rst_data", a_od, 0);
      chk("mid_rst_index", a_oi, 0);
      tick();
      rst_n = 1'b1;
      tick();
      qa.delete(); a_dn = 0;
      a_ready = 1; a_start = 1; tick(); a_start = 0;
      tick(12);
      chk_frame("post_reset", qa, 4);
      chk("post_reset_dn", a_dn, 1);

      // backpressure, FIFO_DEPTH=2
      b_ready = 0; b_start = 1; tick(); b_start = 0;
      tick(8);
      chk("bp_wait_sel", b_rd, 4'b0100);
      chk("bp_wait_busy", b_busy, 1);
      chk("bp_wait_valid", b_ov, 1);
      chk("bp_wait_q", qb.size(), 0);
      b_ready = 1; tick(); b_ready = 0;
      tick(5);
      chk("bp_wait2_sel", b_rd, 4'b1000);
      chk("bp_wait2_q", qb.size(), 1);
      chk("bp_wait2_dn", b_dn, 0);
      b_ready = 1;
      tick(12);
      chk_frame("bp", qb, 4);
      chk("bp_dn", b_dn, 1);

      // SETTLE_CYCLES=0
      c_ready = 1; c_start = 1; tick(); c_start = 0;
      chk("s0_sel0", c_rd, 4'b0001);
      tick();
      chk("s0_sel1", c_rd, 4'b0010);
      tick(2);
      chk("s0_done_early", c_done, 0);
      tick();
      chk("s0_done", c_done, 1);
      tick(4);
      chk_frame("s0", qc, 4);
      chk("s0_dn", c_dn, 1);

      chk("onehot", oh_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
